act_skew_feeder: RTL and testbench

// Upstream activation feeder for the systolic PE array. Accepts one activation

---
 rtl/act_skew_feeder.sv | 132 +++++++++++++
 tb/tb_act_skew_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// Activation feeder for the systolic PE array: buffers input vectors in a FIFO and
// issues them into the left PE column with a one-cycle-per-row diagonal skew.
module act_skew_feeder #(
   parameter int ARRAY_ROWS = 4,
   parameter int ACT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [ARRAY_ROWS*ACT_WIDTH-1:0] in_data,
   input  logic                            in_last,
   input  logic                            array_en,
   output logic [ARRAY_ROWS*ACT_WIDTH-1:0] act_data_out,
   output logic [ARRAY_ROWS-1:0]           act_valid_out,
   output logic                            tile_done,
   output logic                            busy
);

   localparam int DW = ARRAY_ROWS * ACT_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t          state, state_next;
   logic [DW:0]     fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            full, empty, push, pop;
   logic [DW:0]     head;
   logic            pop_last;
   logic [DW-1:0]   pop_data;
   logic [ARRAY_ROWS-1:0] last_pipe, last_next;
   logic            advanced;
   logic            tile_next;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign pop      = array_en && !empty && (state != DRAIN);
   assign head     = fifo_mem[rd_ptr];
   assign pop_last = pop && head[DW];
   assign pop_data = pop ? head[DW-1:0] : '0;
   assign busy     = (state != IDLE) || !empty;

   // NOTE: the storage array is deliberately not reset; count alone says which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {in_last, in_data};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Row r is an (r+1)-deep shift pipe; its last stage drives the PE input directly.
   for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
      logic [ACT_WIDTH-1:0] d_pipe [r+1];
      logic [r:0]           v_pipe;

      always_ff @(posedge clk) begin
         if (!reset) begin
            v_pipe <= '0;
            for (int s = 0; s <= r; s++) d_pipe[s] <= '0;
         end else if (array_en) begin
            d_pipe[0] <= pop_data[r*ACT_WIDTH +: ACT_WIDTH];
            v_pipe[0] <= pop;
            for (int s = 1; s <= r; s++) begin
               d_pipe[s] <= d_pipe[s-1];
               v_pipe[s] <= v_pipe[s-1];
            end
         end
      end

      assign act_data_out[r*ACT_WIDTH +: ACT_WIDTH] = d_pipe[r];
      assign act_valid_out[r]                       = v_pipe[r];
   end

   // The tile-end flag only matters on the bottom row, so it rides its own pipe.
   always_comb begin
      last_next    = '0;
      last_next[0] = pop_last;
      for (int s = 1; s < ARRAY_ROWS; s++) last_next[s] = last_pipe[s-1];
   end

   assign tile_next = array_en && last_next[ARRAY_ROWS-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         last_pipe <= '0;
         advanced  <= 1'b0;
      end else begin
         advanced <= array_en;
         if (array_en) last_pipe <= last_next;
      end
   end

   // A stalled pipe keeps the flag at the output, but only the advancing edge may pulse.
   assign tile_done = last_pipe[ARRAY_ROWS-1] && advanced;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: state_next takes its default first so no path through the case can infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (pop) state_next = pop_last ? DRAIN : STREAM;
         STREAM:  if (pop_last) state_next = DRAIN;
         DRAIN:   ;
         default: state_next = IDLE;
      endcase
      if (tile_next) state_next = IDLE;
   end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Self-checking bench for act_skew_feeder: cycle tables for skew/stall/reset timing,
// a per-row scoreboard for ordering, and hand sequences for full FIFO and back-to-back tiles.
module tb_act_skew_feeder;

   localparam int R  = 4;
   localparam int W  = 8;
   localparam int D  = 8;
   localparam int DW = R * W;

   localparam logic [DW-1:0] V0 = 32'h04030201;
   localparam logic [DW-1:0] V1 = 32'h08070605;
   localparam logic [DW-1:0] V2 = 32'h0C0B0A09;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          array_en;
   logic [DW-1:0] act_data_out;
   logic [R-1:0]  act_valid_out;
   logic          tile_done;
   logic          busy;

   always #5 clk = ~clk;

   act_skew_feeder #(.ARRAY_ROWS(R), .ACT_WIDTH(W), .FIFO_DEPTH(D)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_last       (in_last),
      .array_en      (array_en),
      .act_data_out  (act_data_out),
      .act_valid_out (act_valid_out),
      .tile_done     (tile_done),
      .busy          (busy)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } sb_t;

   typedef struct {
      logic          rst;
      logic          vld;
      logic [DW-1:0] data;
      logic          last;
      logic          en;
      logic [R-1:0]  exp_vld;
      logic [DW-1:0] exp_data;
      logic          exp_done;
      logic          exp_busy;
      logic          exp_ready;
   } vec_t;

   sb_t  sb_q[$];
   int   rd_idx[R];
   vec_t tbl[$];
   int   n_compared = 0;
   int   n_fail     = 0;
   int   n_done     = 0;
   logic adv        = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // One clock: drive inputs, log accepted vectors into the scoreboard, step past the edge.
   task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic l, input logic e);
      reset    = r;
      in_valid = v;
      in_data  = d;
      in_last  = l;
      array_en = e;
      if (r && v && in_ready) sb_q.push_back('{data: d, last: l});
      @(posedge clk);
      if (!r) begin
         sb_q.delete();
         foreach (rd_idx[i]) rd_idx[i] = 0;
      end
      #1;
   endtask

   task automatic add(input logic rst, input logic vld, input logic [DW-1:0] data,
                      input logic last, input logic en, input logic [R-1:0] ev,
                      input logic [DW-1:0] ed, input logic edone, input logic ebusy,
                      input logic erdy);
      tbl.push_back('{rst, vld, data, last, en, ev, ed, edone, ebusy, erdy});
   endtask

   task automatic add_single_tile();
      add(1, 1, V0, 0, 1, 4'b0000, 32'h00000000, 0, 1, 1);
      add(1, 1, V1, 0, 1, 4'b0001, 32'h00000001, 0, 1, 1);
      add(1, 1, V2, 1, 1, 4'b0011, 32'h00000205, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b0111, 32'h00030609, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b1110, 32'h04070A00, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b1100, 32'h080B0000, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b1000, 32'h0C000000, 1, 0, 1);
      add(1, 0, '0, 0, 1, 4'b0000, 32'h00000000, 0, 0, 1);
   endtask

   always @(posedge clk) adv <= array_en;

   // Only cycles that follow an advancing edge present new elements.
   always @(negedge clk) begin
      sb_t e;
      if (reset === 1'b1) begin
         if (!adv) check("stall_no_done", tile_done, 1'b0);
         else begin
            for (int r = 0; r < R; r++) begin
               if (act_valid_out[r]) begin
                  if (rd_idx[r] >= sb_q.size()) begin
                     n_compared++;
                     n_fail++;
                     $display("FAIL sb_row%0d: got 0x%0h, want no element", r,
                              act_data_out[r*W +: W]);
                  end else begin
                     e = sb_q[rd_idx[r]];
                     check($sformatf("sb_row%0d_data", r), act_data_out[r*W +: W],
                           e.data[r*W +: W]);
                     if (r == R - 1) check("sb_tile_done", tile_done, e.last);
                     rd_idx[r]++;
                  end
               end
            end
            if (tile_done) begin
               n_done++;
               check("done_with_bottom_valid", act_valid_out[R-1], 1'b1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, want finish before 100000");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          t;
      logic [DW-1:0] v9;
      int            done0;
      int            done_cyc;
      int            row0_cyc[$];

      reset = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; array_en = 1'b0;

      // Reset: two cycles low, then release.
      cycle(0, 0, '0, 0, 0);
      cycle(0, 0, '0, 0, 0);
      cycle(1, 0, '0, 0, 1);
      check("rst_valid", act_valid_out, '0);
      check("rst_data", act_data_out, '0);
      check("rst_done", tile_done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", in_ready, 1'b1);

      // Single tile.
      add_single_tile();
      // Same tile with a two-cycle stall after the first pop.
      add(1, 1, V0, 0, 1, 4'b0000, 32'h00000000, 0, 1, 1);
      add(1, 1, V1, 0, 1, 4'b0001, 32'h00000001, 0, 1, 1);
      add(1, 1, V2, 1, 0, 4'b0001, 32'h00000001, 0, 1, 1);
      add(1, 0, '0, 0, 0, 4'b0001, 32'h00000001, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b0011, 32'h00000205, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b0111, 32'h00030609, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b1110, 32'h04070A00, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b1100, 32'h080B0000, 0, 1, 1);
      add(1, 0, '0, 0, 1, 4'b1000, 32'h0C000000, 1, 0, 1);
      add(1, 0, '0, 0, 1, 4'b0000, 32'h00000000, 0, 0, 1);
      // Reset two cycles into a tile, quiet period, then a fresh tile with identical timing.
      add(1, 1, V0, 0, 1, 4'b0000, 32'h00000000, 0, 1, 1);
      add(1, 1, V1, 0, 1, 4'b0001, 32'h00000001, 0, 1, 1);
      add(1, 1, V2, 1, 1, 4'b0011, 32'h00000205, 0, 1, 1);
      add(0, 0, '0, 0, 1, 4'b0000, 32'h00000000, 0, 0, 1);
      for (int k = 0; k < 4; k++) add(1, 0, '0, 0, 1, 4'b0000, 32'h00000000, 0, 0, 1);
      add_single_tile();

      foreach (tbl[i]) begin
         t = tbl[i];
         cycle(t.rst, t.vld, t.data, t.last, t.en);
         check($sformatf("tbl%0d_valid", i), act_valid_out, t.exp_vld);
         check($sformatf("tbl%0d_data", i), act_data_out, t.exp_data);
         check($sformatf("tbl%0d_done", i), tile_done, t.exp_done);
         check($sformatf("tbl%0d_busy", i), busy, t.exp_busy);
         check($sformatf("tbl%0d_ready", i), in_ready, t.exp_ready);
      end

      // Full FIFO: eight pushes under stall, ninth held until a pop frees a slot.
      done0 = n_done;
      for (int i = 0; i < D; i++) cycle(1, 1, DW'($urandom()), 0, 0);
      check("full_ready", in_ready, 1'b0);
      check("full_busy", busy, 1'b1);
      v9 = DW'($urandom());
      for (int i = 0; i < 2; i++) begin
         cycle(1, 1, v9, 1, 0);
         check($sformatf("full_hold%0d_ready", i), in_ready, 1'b0);
      end
      cycle(1, 1, v9, 1, 1);
      check("ready_after_pop", in_ready, 1'b1);
      cycle(1, 1, v9, 1, 1);
      for (int k = 0; k < 60 && busy; k++) cycle(1, 0, '0, 0, 1);
      check("full_drained_busy", busy, 1'b0);
      cycle(1, 0, '0, 0, 1);
      check("full_done_count", n_done - done0, 1);

      // Back-to-back tiles: A = 3 vectors, B = 2 vectors, queued together.
      done0    = n_done;
      done_cyc = -1;
      for (int c = 0; c < 30; c++) begin
         cycle(1, c < 5, DW'($urandom()), (c == 2) || (c == 4), 1);
         if (act_valid_out[0]) row0_cyc.push_back(c);
         if (tile_done && done_cyc < 0) done_cyc = c;
      end
      check("b2b_row0_count", row0_cyc.size(), 5);
      if (row0_cyc.size() == 5) begin
         check("b2b_row0_bubbles", row0_cyc[3] - row0_cyc[2] - 1, R - 1);
         check("b2b_first_after_done", row0_cyc[3], done_cyc + 1);
      end
      check("b2b_done_count", n_done - done0, 2);

      for (int r = 0; r < R; r++)
         check($sformatf("sb_drained_row%0d", r), rd_idx[r], sb_q.size());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_fail);
      $finish;
   end

endmodule
